// File: rtl/serial_addsub_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: state encoding,
// mode constants and the parameter legality check used at elaboration.
package serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  // The chunk loop only covers the operand exactly when the chunk size divides the width.
  function automatic bit params_ok(input int width, input int bits_per_cycle);
    return (width >= 2) && (bits_per_cycle >= 1) && ((width % bits_per_cycle) == 0);
  endfunction

endpackage

// File: rtl/serial_addsub_fa_bit.sv
// One-bit full-adder cell; chained BITS_PER_CYCLE times inside serial_addsub.
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic z,
  output logic co
);

  assign z  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_addsub.sv
// Sequential adder/subtractor: BITS_PER_CYCLE bits per clock through a ripple
// chain of fa_bit cells, with start/busy/done handshake and carry/overflow/zero flags.
//
// state | meaning
// IDLE  | waiting for start
// RUN   | one operand chunk consumed per edge
// DONE  | results valid for one cycle (done=1); start here is accepted
module serial_addsub
  import serial_addsub_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int BITS_PER_CYCLE = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic [WIDTH-1:0] z,
  output logic             co,
  output logic             ov,
  output logic             zero,
  output logic             busy,
  output logic             done
);

  localparam int BPC = BITS_PER_CYCLE;
  localparam int N   = WIDTH / BPC;
  localparam int CW  = (N > 1) ? $clog2(N) : 1;

  generate
    if (!params_ok(WIDTH, BITS_PER_CYCLE)) begin : g_bad_params
      $error("serial_addsub: WIDTH must be >= 2 and a multiple of BITS_PER_CYCLE");
    end
  endgenerate

  state_t           state, state_nxt;
  logic [WIDTH-1:0] op_a, op_b, res_sh, res_next;
  logic             carry;
  logic [CW-1:0]    cnt;
  logic [BPC:0]     chain;
  logic [BPC-1:0]   sum_chunk;
  logic             accept, last;

  assign chain[0] = carry;

  generate
    for (genvar i = 0; i < BPC; i++) begin : g_chain
      fa_bit u_fa (
        .a  (op_a[i]),
        .b  (op_b[i]),
        .ci (chain[i]),
        .z  (sum_chunk[i]),
        .co (chain[i+1])
      );
    end
  endgenerate

  // Sum chunks enter at the top so the first (least significant) chunk ends at bit 0.
  assign res_next = (res_sh >> BPC) | (WIDTH'(sum_chunk) << (WIDTH - BPC));

  assign accept = start && (state != RUN);
  assign last   = (cnt == CW'(N - 1));
  assign busy   = (state == RUN);
  assign done   = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (last)  state_nxt = DONE;
      DONE:    state_nxt = start ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      op_a   <= '0;
      op_b   <= '0;
      res_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      z      <= '0;
      co     <= 1'b0;
      ov     <= 1'b0;
      zero   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_a   <= a;
        op_b   <= (mode == MODE_ADD) ? b : ~b;
        carry  <= (mode == MODE_ADD) ? ci : ~ci;
        res_sh <= '0;
        cnt    <= '0;
      end else if (state == RUN) begin
        op_a   <= op_a >> BPC;
        op_b   <= op_b >> BPC;
        res_sh <= res_next;
        carry  <= chain[BPC];
        cnt    <= cnt + CW'(1);
        if (last) begin
          z    <= res_next;
          co   <= chain[BPC];
          ov   <= chain[BPC] ^ chain[BPC-1];
          zero <= (res_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: an arithmetic reference model checked every cycle
// against a 1-bit-per-cycle and a 4-bit-per-cycle instance, plus literal checks.
module tb_serial_addsub;

  logic       clk = 1'b0;
  logic       rst, start, mode, ci;
  logic [7:0] a, b;
  logic [7:0] z_o [2];
  logic       co_o [2], ov_o [2], zero_o [2], busy_o [2], done_o [2];

  int checks   = 0;
  int failures = 0;
  bit chk_en   = 1'b0;

  always #5 clk = ~clk;

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(1)) u_dut1 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .ci(ci),
    .z(z_o[0]), .co(co_o[0]), .ov(ov_o[0]), .zero(zero_o[0]),
    .busy(busy_o[0]), .done(done_o[0])
  );

  serial_addsub #(.WIDTH(8), .BITS_PER_CYCLE(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .mode(mode), .a(a), .b(b), .ci(ci),
    .z(z_o[1]), .co(co_o[1]), .ov(ov_o[1]), .zero(zero_o[1]),
    .busy(busy_o[1]), .done(done_o[1])
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: operations complete NCH cycles after acceptance.
  int         nch [2] = '{8, 2};
  int         edge_n = 0;
  int         due [2];
  bit         mbusy [2], mdone [2];
  logic [7:0] mz [2], pz [2];
  bit         mco [2], mov [2], mzero [2], pco [2], pov [2], pzero [2];

  always @(posedge clk) begin
    int ia, ib, ic, sa, sb, full, sres;
    bit was_busy;
    edge_n++;
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        mbusy[k] = 0; mdone[k] = 0;
        mz[k] = '0; mco[k] = 0; mov[k] = 0; mzero[k] = 0;
      end else begin
        was_busy = mbusy[k];
        mdone[k] = 0;
        if (was_busy && edge_n == due[k]) begin
          mz[k] = pz[k]; mco[k] = pco[k]; mov[k] = pov[k]; mzero[k] = pzero[k];
          mbusy[k] = 0; mdone[k] = 1;
        end
        if (start && !was_busy) begin
          ia = int'(a); ib = int'(b); ic = int'(ci);
          sa = (ia >= 128) ? ia - 256 : ia;
          sb = (ib >= 128) ? ib - 256 : ib;
          if (mode == 1'b0) begin
            full = ia + ib + ic; pco[k] = (full > 255); sres = sa + sb + ic;
          end else begin
            full = ia - ib - ic; pco[k] = (full >= 0);  sres = sa - sb - ic;
          end
          pz[k]    = 8'(full);
          pzero[k] = (8'(full) == 8'd0);
          pov[k]   = (sres > 127) || (sres < -128);
          mbusy[k] = 1;
          due[k]   = edge_n + nch[k];
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("busy%0d", k), busy_o[k], mbusy[k]);
        chk($sformatf("done%0d", k), done_o[k], mdone[k]);
        chk($sformatf("z%0d", k),    z_o[k],    mz[k]);
        chk($sformatf("co%0d", k),   co_o[k],   mco[k]);
        chk($sformatf("ov%0d", k),   ov_o[k],   mov[k]);
        chk($sformatf("zero%0d", k), zero_o[k], mzero[k]);
      end
    end
  end

  // Start is held across one rising edge; operands are then scrambled.
  task automatic issue(input logic m, input logic [7:0] va, input logic [7:0] vb, input logic vc);
    start = 1'b1; mode = m; a = va; b = vb; ci = vc;
    @(negedge clk);
    start = 1'b0; a = ~va ^ 8'h5A; b = ~vb; ci = ~vc; mode = ~m;
  endtask

  task automatic wait_done(input int k, input int c0, output int lat);
    lat = c0;
    while (!done_o[k] && lat < 20) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic chk_res(input string name, input logic [7:0] ez, input bit eco,
                         input bit eov, input bit ezero);
    chk({name, "_z"},    z_o[0],    ez);
    chk({name, "_co"},   co_o[0],   eco);
    chk({name, "_ov"},   ov_o[0],   eov);
    chk({name, "_zero"}, zero_o[0], ezero);
  endtask

  initial begin
    int lat, seen;
    rst = 1'b1; start = 1'b0; mode = 1'b0; a = '0; b = '0; ci = 1'b0;
    @(negedge clk);
    chk_en = 1'b1;
    @(negedge clk);
    chk_res("reset", 8'h00, 0, 0, 0);
    chk("reset_busy", busy_o[0], 1'b0);
    chk("reset_done", done_o[0], 1'b0);
    rst = 1'b0;
    @(negedge clk);

    issue(1'b0, 8'h7F, 8'h01, 1'b0);
    wait_done(0, 0, lat);
    chk("add_latency", lat, 8);
    chk_res("add7f", 8'h80, 0, 1, 0);
    @(negedge clk);

    issue(1'b1, 8'h05, 8'h07, 1'b0);
    wait_done(0, 0, lat);
    chk_res("sub05", 8'hFE, 0, 0, 0);
    @(negedge clk);

    issue(1'b1, 8'h80, 8'h01, 1'b0);
    wait_done(0, 0, lat);
    chk_res("sub80", 8'h7F, 1, 1, 0);
    @(negedge clk);

    issue(1'b0, 8'hFF, 8'h00, 1'b1);
    wait_done(0, 0, lat);
    chk_res("addff", 8'h00, 1, 0, 1);
    issue(1'b0, 8'h12, 8'h34, 1'b0);
    chk("b2b_busy", busy_o[0], 1'b1);
    wait_done(0, 0, lat);
    chk("b2b_latency", lat, 8);
    chk_res("b2b", 8'h46, 0, 0, 0);
    @(negedge clk);

    issue(1'b0, 8'h10, 8'h20, 1'b0);
    @(negedge clk);
    @(negedge clk);
    start = 1'b1; mode = 1'b1; a = 8'hAA; b = 8'h55; ci = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(0, 3, lat);
    chk("ignore_latency", lat, 8);
    chk_res("ignore", 8'h30, 0, 0, 0);
    @(negedge clk);

    issue(1'b0, 8'h33, 8'h44, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      if (done_o[0]) seen++;
      @(negedge clk);
    end
    chk("abort_no_done", seen, 0);
    chk_res("abort", 8'h00, 0, 0, 0);

    issue(1'b0, 8'h3C, 8'h0F, 1'b0);
    wait_done(1, 0, lat);
    chk("bpc4_latency", lat, 2);
    chk("bpc4_z", z_o[1], 8'h4B);
    repeat (10) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_addsub.md
Name: serial_addsub

Overview:
- Parametrised multi-bit adder-subtractor built as a sequential datapath. It processes BITS_PER_CYCLE bits per clock through a chain of one-bit full-adder cells, so one adder slice serves any operand width.
- Adds a start/busy/done handshake and an add/subtract mode, and reports carry, signed overflow and zero flags.
- Sits between operand registers and the ALU result bus in the arithmetic datapath.

Parameters:
- WIDTH, 8, operand and result width in bits; must be ≥ 2.
- BITS_PER_CYCLE, 1, bits processed per clock; must divide WIDTH exactly.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request; accepted only when busy=0.
- mode  input  1  0 = add, 1 = subtract; sampled with start.
- a  input  WIDTH  operand A (unsigned or two's complement); sampled with start.
- b  input  WIDTH  operand B; sampled with start.
- ci  input  1  carry-in for add, borrow-in for subtract; sampled with start.
- z  output  WIDTH  result.
- co  output  1  carry-out (in subtract mode, 1 means no borrow).
- ov  output  1  signed overflow.
- zero  output  1  asserted when z == 0.
- busy  output  1  high while an operation is in RUN.
- done  output  1  one-cycle pulse when the results become valid.

Behaviour:
- Reset
  - One clock and a synchronous, active-high reset on rst.
  - On any edge with rst=1: state←IDLE, z←0, co←0, ov←0, zero←0, busy←0, done←0, internal registers←0.
  - rst overrides start.
  - rst during RUN aborts the operation; no done pulse is produced.
- States: IDLE, RUN, DONE.
  - IDLE/DONE → RUN on start=1.
  - RUN → DONE after N = WIDTH/BITS_PER_CYCLE chunk edges.
  - DONE → IDLE after one cycle when start=0.
- Accept edge (start=1, busy=0)
  - Latch a into opA.
  - Latch b into opB, or ~b when mode=1.
  - Carry register ← ci for add, ~ci for subtract.
  - Chunk counter ← 0.
  - busy←1 from the next cycle.
- Arithmetic
  - Add computes a + b + ci.
  - Subtract computes a + ~b + ~ci, which equals a − b − ci mod 2^WIDTH.
- RUN, each edge
  - The low BITS_PER_CYCLE bits of opA/opB plus the carry register pass through the full-adder chain.
  - The sum chunk shifts into the top of the result shift register; opA and opB shift right by BITS_PER_CYCLE.
  - The carry register takes the chain carry-out.
  - The counter increments.
- On the Nth RUN edge
  - z ← assembled result.
  - co ← final carry.
  - ov ← carry into the MSB XOR carry out of the MSB.
  - zero ← (result == 0).
  - busy←0, done←1, state←DONE.
- Latency: done is high exactly N cycles after the accept edge.
- Holding and reuse
  - z, co, ov and zero hold until the next completion or reset. They are not cleared by a new start.
  - start while busy=1 is ignored; it is not queued.
  - start during the DONE cycle is accepted (back-to-back throughput of one op per N+1 cycles).
  - Operand changes after the accept edge have no effect.
- done is never high for two consecutive cycles.

Decomposition:
- Shared arithmetic package holds:
  - state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - mode constants MODE_ADD=1'b0, MODE_SUB=1'b1;
  - elaboration check that WIDTH % BITS_PER_CYCLE == 0.
- One sub-module, fa_bit (inputs a, b, ci; outputs z, co). It is instantiated BITS_PER_CYCLE times as a ripple chain via a generate loop.
- The FSM, counter and shift registers stay in serial_addsub.

Test Plan:
- WIDTH=8, BPC=1; reset held 2 cycles → all outputs 0; busy=0.
- start, mode=0, a=0x7F, b=0x01, ci=0 → done 8 cycles later; z=0x80, co=0, ov=1, zero=0.
- start, mode=1, a=0x05, b=0x07, ci=0 → z=0xFE, co=0, ov=0; then mode=1, a=0x80, b=0x01 → z=0x7F, co=1, ov=1.
- mode=0, a=0xFF, b=0x00, ci=1 → z=0x00, co=1, zero=1, ov=0. Re-issue start on the done cycle → accepted; busy=1 the next cycle.
- start pulsed again at cycle 3 of RUN with different operands → ignored; the original result is returned on schedule.
- rst asserted at cycle 4 of RUN → no done pulse, outputs 0.
- WIDTH=8, BPC=4; a=0x3C, b=0x0F, add → done 2 cycles after accept, z=0x4B.
